writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 77 +++++++
 rtl/writeback_arbiter.sv | 114 +++++++++++
 tb/tb_writeback_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback path.
package wb_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned XLEN      = 32;

  // One queued LSU result: destination index plus write data.
  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_entry_t;

  // A source index hits a pending destination only when it names a real
  // register; x0 is never a hazard.
  function automatic logic idx_hit(input logic [REG_IDX_W-1:0] src,
                                   input logic [REG_IDX_W-1:0] dst);
    return (src != '0) && (src == dst);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// LSU result FIFO for the writeback arbiter.
// Wrapping read/write pointers plus an occupancy count one bit wider than
// the pointers, so full (count==DEPTH) and empty (count==0) are unambiguous.
// With WB_HAZARD_EN defined, the destination index of every slot and a
// per-slot occupancy vector are exported for the hazard comparators.
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  wb_entry_t            push_entry,
  input  logic                 pop,
  output wb_entry_t            head,
  output logic                 full,
  output logic                 empty,
  output logic [CNT_W-1:0]     count
`ifdef WB_HAZARD_EN
  ,
  output logic [REG_IDX_W-1:0] slot_rd [DEPTH],
  output logic [DEPTH-1:0]     slot_valid
`endif
);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are qualified by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= push_entry;
  end

`ifdef WB_HAZARD_EN
  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    offset     = '0;
    slot_valid = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset        = PTR_W'(i) - rd_ptr;
      slot_valid[i] = ({1'b0, offset} < count);
      slot_rd[i]    = mem[i].rd;
    end
  end
`endif

endmodule

// File: rtl/writeback_arbiter.sv
// Register-file writeback arbiter.
// ALU results have strict priority and write one cycle after they appear.
// LSU results are queued in wb_fifo and drained whenever the ALU is idle.
// Optional build macro WB_HAZARD_EN adds decode-stage hazard flags that
// report sources with a pending LSU write.
module writeback_arbiter
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [REG_IDX_W-1:0] alu_rd,
  input  logic [XLEN-1:0]      alu_data,
  input  logic                 lsu_valid,
  output logic                 lsu_ready,
  input  logic [REG_IDX_W-1:0] lsu_rd,
  input  logic [XLEN-1:0]      lsu_data,
  output logic                 reg_wr_en,
  output logic [REG_IDX_W-1:0] rd,
  output logic [XLEN-1:0]      rd_data,
  input  logic [REG_IDX_W-1:0] chk_rs1,
  input  logic [REG_IDX_W-1:0] chk_rs2,
  output logic                 haz_rs1,
  output logic                 haz_rs2
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  wb_entry_t        fifo_head;
  wb_entry_t        push_entry;
  logic             push;
  logic             pop;

  // lsu_ready depends only on registered occupancy, never on this cycle's pop.
  assign lsu_ready  = !fifo_full;
  // Writes to x0 are acknowledged but never take a FIFO slot.
  assign push       = lsu_valid && lsu_ready && (lsu_rd != '0);
  // The head drains only in cycles the ALU leaves free, including alu_rd==0.
  assign pop        = !alu_valid && !fifo_empty;
  assign push_entry = '{rd: lsu_rd, data: lsu_data};

`ifdef WB_HAZARD_EN
  logic [REG_IDX_W-1:0] slot_rd [DEPTH];
  logic [DEPTH-1:0]     slot_valid;
`endif

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
`ifdef WB_HAZARD_EN
    ,
    .slot_rd    (slot_rd),
    .slot_valid (slot_valid)
`endif
  );

  // Single registered write port: ALU first, otherwise the FIFO head.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_wr_en <= 1'b0;
      rd        <= '0;
      rd_data   <= '0;
    end else if (alu_valid) begin
      reg_wr_en <= (alu_rd != '0);
      if (alu_rd != '0) begin
        rd      <= alu_rd;
        rd_data <= alu_data;
      end
    end else if (pop) begin
      reg_wr_en <= 1'b1;
      rd        <= fifo_head.rd;
      rd_data   <= fifo_head.data;
    end else begin
      reg_wr_en <= 1'b0;
    end
  end

`ifdef WB_HAZARD_EN
  logic unused_sink;
  assign unused_sink = ^fifo_count;

  // A source is hazardous if any live slot, or the result entering now, targets it.
  always_comb begin
    haz_rs1 = push && idx_hit(chk_rs1, lsu_rd);
    haz_rs2 = push && idx_hit(chk_rs2, lsu_rd);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (slot_valid[i]) begin
        haz_rs1 = haz_rs1 || idx_hit(chk_rs1, slot_rd[i]);
        haz_rs2 = haz_rs2 || idx_hit(chk_rs2, slot_rd[i]);
      end
    end
  end
`else
  logic unused_sink;
  assign unused_sink = ^{fifo_count, chk_rs1, chk_rs2};
  assign haz_rs1     = 1'b0;
  assign haz_rs2     = 1'b0;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed self-checking bench for writeback_arbiter (DEPTH=4).
// Hazard expectations follow WB_HAZARD_EN: flags must stay 0 when undefined.
module tb_writeback_arbiter;

`ifdef WB_HAZARD_EN
  localparam logic HAZ = 1'b1;
`else
  localparam logic HAZ = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        reg_wr_en;
  logic [4:0]  rd;
  logic [31:0] rd_data;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        haz_rs1;
  logic        haz_rs2;

  int total = 0;
  int bad   = 0;

  writeback_arbiter #(
    .DEPTH(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .lsu_valid (lsu_valid),
    .lsu_ready (lsu_ready),
    .lsu_rd    (lsu_rd),
    .lsu_data  (lsu_data),
    .reg_wr_en (reg_wr_en),
    .rd        (rd),
    .rd_data   (rd_data),
    .chk_rs1   (chk_rs1),
    .chk_rs2   (chk_rs2),
    .haz_rs1   (haz_rs1),
    .haz_rs2   (haz_rs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    alu_rd    = '0;
    alu_data  = '0;
    lsu_valid = 1'b0;
    lsu_rd    = '0;
    lsu_data  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    reset   = 1'b1;
    chk_rs1 = '0;
    chk_rs2 = '0;
    idle();
    step();
    step();
    reset = 1'b0;
    check("rst_wr_en", reg_wr_en, 0);
    check("rst_rd",    rd, 0);
    check("rst_data",  rd_data, 0);
    check("rst_ready", lsu_ready, 1);
    check("rst_haz1",  haz_rs1, 0);

    // ALU write: one-cycle latency, then outputs hold.
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    idle();
    check("alu_wr_en", reg_wr_en, 1);
    check("alu_rd",    rd, 5);
    check("alu_data",  rd_data, 32'hDEAD_BEEF);
    step();
    check("alu_idle_wr_en", reg_wr_en, 0);
    check("hold_rd",        rd, 5);
    check("hold_data",      rd_data, 32'hDEAD_BEEF);

    // Single LSU result: enqueue edge, then write one edge later.
    lsu_valid = 1'b1; lsu_rd = 5'd7; lsu_data = 32'h1234;
    check("lsu_ready", lsu_ready, 1);
    step();
    idle();
    check("lsu_enq_wr_en", reg_wr_en, 0);
    step();
    check("lsu_wr_en", reg_wr_en, 1);
    check("lsu_rd",    rd, 7);
    check("lsu_data",  rd_data, 32'h1234);
    step();
    check("lsu_after_wr_en", reg_wr_en, 0);

    // ALU busy for 6 cycles while LSU fills the queue and a 5th waits.
    for (int c = 0; c < 6; c++) begin
      k = (c < 4) ? c : 4;
      alu_valid = 1'b1; alu_rd = 5'(10 + c); alu_data = 32'hA0 + c;
      lsu_valid = 1'b1; lsu_rd = 5'(20 + k); lsu_data = 32'h100 + k;
      check("burst_ready", lsu_ready, (c < 4) ? 1 : 0);
      step();
      check("burst_wr_en", reg_wr_en, 1);
      check("burst_alu_rd", rd, 10 + c);
    end
    alu_valid = 1'b0; alu_rd = '0;
    check("full_ready_on_pop", lsu_ready, 0);
    step();
    check("drain0_wr_en", reg_wr_en, 1);
    check("drain0_rd",    rd, 20);
    check("drain0_data",  rd_data, 32'h100);
    check("ready_after_pop", lsu_ready, 1);
    step();
    lsu_valid = 1'b0;
    check("drain1_rd",   rd, 21);
    check("drain1_data", rd_data, 32'h101);
    for (int i = 2; i < 5; i++) begin
      step();
      check("drain_wr_en", reg_wr_en, 1);
      check("drain_rd",    rd, 20 + i);
      check("drain_data",  rd_data, 32'h100 + i);
    end
    step();
    check("drained_wr_en", reg_wr_en, 0);

    // x0 destinations: ALU suppresses the write, LSU is acked but not queued.
    alu_valid = 1'b1; alu_rd = '0; alu_data = 32'hBAD;
    lsu_valid = 1'b1; lsu_rd = '0; lsu_data = 32'hBAD;
    step();
    idle();
    check("x0_wr_en",  reg_wr_en, 0);
    check("x0_rd",     rd, 24);
    check("x0_ready",  lsu_ready, 1);
    step();
    check("x0_not_queued", reg_wr_en, 0);

    // ALU to x0 must not let the queued head through that cycle.
    lsu_valid = 1'b1; lsu_rd = 5'd3; lsu_data = 32'h33;
    step();
    idle();
    alu_valid = 1'b1; alu_rd = '0; alu_data = 32'h77;
    step();
    idle();
    check("x0_blocks_pop_wr_en", reg_wr_en, 0);
    check("x0_blocks_pop_rd",    rd, 24);
    step();
    check("held_head_wr_en", reg_wr_en, 1);
    check("held_head_rd",    rd, 3);
    check("held_head_data",  rd_data, 32'h33);

    // Hazard visibility while entries sit behind a busy ALU.
    chk_rs1 = 5'd9; chk_rs2 = '0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd1; alu_data = i;
      lsu_valid = 1'b1; lsu_rd = 5'(9 + i); lsu_data = 32'h900 + i;
      if (i == 0) check("haz_accepting", haz_rs1, HAZ);
      step();
    end
    idle();
    check("haz1_queued", haz_rs1, HAZ);
    check("haz2_x0",     haz_rs2, 0);
    check("full_ready",  lsu_ready, 0);
    chk_rs2 = 5'd11;
    check("haz2_queued", haz_rs2, HAZ);
    step();
    check("haz_pop_rd",    rd, 9);
    check("haz_pop_data",  rd_data, 32'h900);
    check("haz1_popped",   haz_rs1, 0);
    check("haz2_still",    haz_rs2, HAZ);

    // Reset with three entries queued and a handshake in the reset cycle.
    reset = 1'b1;
    lsu_valid = 1'b1; lsu_rd = 5'd13; lsu_data = 32'hD;
    step();
    reset = 1'b0;
    idle();
    chk_rs1 = 5'd13; chk_rs2 = 5'd10;
    check("flush_wr_en", reg_wr_en, 0);
    check("flush_rd",    rd, 0);
    check("flush_data",  rd_data, 0);
    check("flush_ready", lsu_ready, 1);
    check("flush_haz1",  haz_rs1, 0);
    check("flush_haz2",  haz_rs2, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("flush_no_wr", reg_wr_en, 0);
    end

    // Empty after flush: exactly four more results fit.
    chk_rs1 = '0; chk_rs2 = '0;
    for (int i = 0; i < 5; i++) begin
      alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2;
      lsu_valid = 1'b1; lsu_rd = 5'd1; lsu_data = i;
      check("refill_ready", lsu_ready, (i < 4) ? 1 : 0);
      step();
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
